seg_scan_driver: RTL

Parametrised multiplexed seven-segment scan driver for the digital clock and later display designs. It owns its scan counter and dwell timing internally, so the only clock in the design drives it directly. It adds digit-count scaling, a built-in hex-to-segment decode, decimal points, leading-zero blanking, per-digit blink and PWM brightness. It sits between the time/count datapath (packed BCD nibbles) and the board's common-anode digit selects and segment lines.

---
 rtl/seg_pkg.sv | 48 ++++
 rtl/seg7_decode.sv | 17 +
 rtl/seg_scan_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment encoding for the display designs.
//   Segment patterns are active-low, 7 bits ordered {g,f,e,d,c,b,a}.
//   A full segment byte is {dp,g,f,e,d,c,b,a}, also active-low.
//   SEG_BLANK is the all-dark byte. hex_to_seg maps a nibble to its pattern.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03; // lower-case b
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21; // lower-case d
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble -> active-low segment byte.
//   nib   in  4  hex value to render
//   dp    in  1  decimal point request, 1 = lit
//   blank in  1  1 = all seven segments dark (dp still honoured)
//   seg   out 8  {dp,g,f,e,d,c,b,a}, active-low
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    assign seg = {~dp, blank ? SEG_OFF : hex_to_seg(nib)};

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed common-anode seven-segment scan driver.
//   clk, rst        clock and async active-high reset
//   digits_in       packed BCD/hex nibbles, [4k+3:4k] is digit k (0 = rightmost)
//   dp_in           per-digit decimal point, 1 = lit
//   blank_lz        1 = suppress leading zeros
//   blink_mask      per-digit blink participation
//   blink_phase     live blink level, 1 = masked digits dark
//   bright          PWM brightness, 0 = dimmest
//   sel             active-low one-hot digit enable
//   seg             active-low {dp,g,f,e,d,c,b,a}
//   display_num     snapshot nibble of the digit being scanned
//   frame_done      one-cycle pulse after the last digit's slot
// All outputs are registered and reflect tick/idx of the previous cycle.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 100000,
    parameter int DUTY_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  blink_phase,
    input  logic [DUTY_W-1:0]     bright,
    output logic [N_DIGITS-1:0]   sel,
    output logic [7:0]            seg,
    output logic [3:0]            display_num,
    output logic                  frame_done
);

    localparam int TW   = $clog2(SCAN_DIV);
    localparam int IW   = $clog2(N_DIGITS);
    localparam int UNIT = SCAN_DIV >> DUTY_W;
    // Wide enough to hold (2**DUTY_W)*UNIT without wrapping.
    localparam int WW   = DUTY_W + $clog2(UNIT) + 1;

    logic [TW-1:0]         tick;
    logic [IW-1:0]         idx;
    logic                  first;
    logic [4*N_DIGITS-1:0] snap_digits;
    logic [N_DIGITS-1:0]   snap_dp;
    logic [N_DIGITS-1:0]   snap_blink;

    logic tick_wrap, last_digit, snap_load;
    assign tick_wrap  = (tick == TW'(SCAN_DIV - 1));
    assign last_digit = (idx == IW'(N_DIGITS - 1));
    // Reload on the edge that moves idx back to 0, so the whole next frame
    // (including the guard cycle of digit 0) sees one coherent snapshot.
    assign snap_load  = first || (tick_wrap && last_digit);

    // Leading-zero chain: zero_up[k] = digit k and all higher digits are 0.
    logic [N_DIGITS-1:0] zero_up;
    always_comb begin
        logic run;
        run     = 1'b1;
        zero_up = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            run        = run && (snap_digits[4*k +: 4] == 4'd0);
            zero_up[k] = run;
        end
    end

    logic [3:0]    cur_nib;
    logic          cur_blank;
    logic [WW-1:0] win_end;
    logic          on_win, lit;
    logic [7:0]    dec_seg;

    assign cur_nib   = snap_digits[{idx, 2'b00} +: 4];
    assign cur_blank = blank_lz && zero_up[idx] && (idx != '0);
    assign win_end   = (WW'(bright) + WW'(1)) * WW'(UNIT);
    // Tick 0 is always dark (guard against ghosting between digits).
    assign on_win    = (tick != '0) && (WW'(tick) < win_end);
    assign lit       = on_win && !(blink_phase && snap_blink[idx]);

    seg7_decode u_dec (
        .nib   (cur_nib),
        .dp    (snap_dp[idx]),
        .blank (cur_blank),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick        <= '0;
            idx         <= '0;
            first       <= 1'b1;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blink  <= '0;
            sel         <= '1;
            seg         <= SEG_BLANK;
            display_num <= '0;
            frame_done  <= 1'b0;
        end else begin
            first <= 1'b0;
            if (tick_wrap) begin
                tick <= '0;
                idx  <= last_digit ? '0 : idx + IW'(1);
            end else begin
                tick <= tick + TW'(1);
            end
            if (snap_load) begin
                snap_digits <= digits_in;
                snap_dp     <= dp_in;
                snap_blink  <= blink_mask;
            end
            sel         <= lit ? ~(N_DIGITS'(1) << idx) : '1;
            seg         <= lit ? dec_seg : SEG_BLANK;
            display_num <= cur_nib;
            frame_done  <= tick_wrap && last_digit;
        end
    end

endmodule
